rf_alu_sequencer: RTL

//  Multi-cycle command sequencer for the 4-bit alu + register_file datapath (rd <= rs1 OP rs2).

---
 rtl/rf_alu_sequencer_pkg.sv | 32 +++
 rtl/rf_alu_sequencer_cmd_latch.sv | 33 +++
 rtl/rf_alu_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/rf_alu_sequencer_pkg.sv
// Shared constants and types for the register-file/ALU command sequencer.
// Opcode encodings, FSM state encoding and the latched command layout live here.
package rf_alu_sequencer_pkg;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 2;
    localparam int OP_W   = 3;
    localparam int CNT_W  = 4;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_NAND = 3'b001;
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
    localparam logic [OP_W-1:0] OP_SLT  = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ_A = 3'd1,
        ST_READ_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WRITE  = 3'd4
    } state_t;

    // A shared source register needs only one read, so READ_B is skipped.
    function automatic state_t after_read_a(input logic [ADDR_W-1:0] rs1,
                                            input logic [ADDR_W-1:0] rs2);
        return (rs1 == rs2) ? ST_EXEC : ST_READ_B;
    endfunction

endpackage

// File: rtl/rf_alu_sequencer_cmd_latch.sv
// Holds the accepted command (op/rd/rs1/rs2) for the duration of its execution.
// Loads on the accept edge and clears asynchronously on reset.
module rf_alu_sequencer_cmd_latch
    import rf_alu_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    output logic [OP_W-1:0]   op,
    output logic [ADDR_W-1:0] rd,
    output logic [ADDR_W-1:0] rs1,
    output logic [ADDR_W-1:0] rs2
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op  <= '0;
            rd  <= '0;
            rs1 <= '0;
            rs2 <= '0;
        end else if (load) begin
            op  <= cmd_op;
            rd  <= cmd_rd;
            rs1 <= cmd_rs1;
            rs2 <= cmd_rs2;
        end
    end

endmodule

// File: rtl/rf_alu_sequencer.sv
// Multi-cycle sequencer for rd <= rs1 OP rs2 over a single-read-port register file
// and an external combinational ALU: read A, read B, execute, write back.
module rf_alu_sequencer
    import rf_alu_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    output logic [ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic [ADDR_W-1:0] rf_we_addr,
    output logic [DATA_W-1:0] rf_we_data,
    output logic              rf_we,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_control,
    input  logic [DATA_W-1:0] alu_res,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [CNT_W-1:0]  cmd_count
);

    state_t            state;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] res_q;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              accept;

    assign accept = cmd_valid && (state == ST_IDLE);

    rf_alu_sequencer_cmd_latch u_cmd_latch (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .cmd_op  (cmd_op),
        .cmd_rd  (cmd_rd),
        .cmd_rs1 (cmd_rs1),
        .cmd_rs2 (cmd_rs2),
        .op      (op),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            res_q     <= '0;
            done      <= 1'b0;
            result    <= '0;
            cmd_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state <= ST_READ_A;
                    end
                end
                ST_READ_A: begin
                    op_a <= rf_rd_data;
                    if (rs1 == rs2) begin
                        op_b <= rf_rd_data;
                    end
                    state <= after_read_a(rs1, rs2);
                end
                ST_READ_B: begin
                    op_b  <= rf_rd_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_q <= alu_res;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    result    <= res_q;
                    done      <= 1'b1;
                    cmd_count <= cmd_count + 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded straight from the state register so an async reset drops the write enable at once.
    assign cmd_ready   = (state == ST_IDLE);
    assign rf_we       = (state == ST_WRITE);
    assign rf_we_addr  = rd;
    assign rf_we_data  = res_q;
    assign rf_rd_addr  = (state == ST_READ_B) ? rs2 : rs1;
    assign alu_a       = op_a;
    assign alu_b       = op_b;
    assign alu_control = op;

endmodule
